// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: two-core MSI snooping bus controller arbitrating dcache/icache traffic onto one RAM port.
module coherence_bus_ctrl #(
    parameter int WORD_W  = 32,
    parameter bit RR_INIT = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             dren_i,
    input  logic [1:0]             dwen_i,
    input  logic [1:0][WORD_W-1:0] daddr_i,
    input  logic [1:0][WORD_W-1:0] dstore_i,
    input  logic [1:0]             cctrans_i,
    input  logic [1:0]             ccwrite_i,
    input  logic [1:0]             iren_i,
    input  logic [1:0][WORD_W-1:0] iaddr_i,
    output logic [1:0]             dwait_o,
    output logic [1:0][WORD_W-1:0] dload_o,
    output logic [1:0]             ccwait_o,
    output logic [1:0]             ccinv_o,
    output logic [1:0][WORD_W-1:0] ccsnoopaddr_o,
    output logic [1:0]             iwait_o,
    output logic [1:0][WORD_W-1:0] iload_o,
    output logic                   ram_ren_o,
    output logic                   ram_wen_o,
    output logic [WORD_W-1:0]      ram_addr_o,
    output logic [WORD_W-1:0]      ram_store_o,
    input  logic [WORD_W-1:0]      ram_load_i,
    input  logic [1:0]             ram_state_i
);
    typedef enum logic [2:0] {IDLE, SNOOP, INV, FWD, MEMR, MEMW, IFETCH} state_t;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    state_t                   state_q;
    logic                     r_q, rr_q, irr_q;
    logic [1:0]               dwait_q, iwait_q, ccwait_q, ccinv_q;
    logic [1:0][WORD_W-1:0]   dload_q, iload_q, ccsnoopaddr_q;
    logic                     ram_ren_q, ram_wen_q;
    logic [WORD_W-1:0]        ram_addr_q, ram_store_q;
    logic [1:0]               dreq;
    logic                     dsel, isel, o, acc, quiet;
    assign dreq  = (dren_i | dwen_i | (cctrans_i & ccwrite_i)) & ~ccwait_q;
    assign dsel  = &dreq ? rr_q : dreq[1];
    assign isel  = &iren_i ? irr_q : iren_i[1];
    assign o     = ~r_q;
    assign acc   = ram_state_i == RAM_ACCESS;
    // a done pulse is still visible to the caches this cycle, so hold off re-granting
    assign quiet = &dwait_q & &iwait_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            r_q           <= 1'b0;
            rr_q          <= RR_INIT;
            irr_q         <= RR_INIT;
            dwait_q       <= 2'b11;
            iwait_q       <= 2'b11;
            ccwait_q      <= 2'b00;
            ccinv_q       <= 2'b00;
            dload_q       <= '0;
            iload_q       <= '0;
            ccsnoopaddr_q <= '0;
            ram_ren_q     <= 1'b0;
            ram_wen_q     <= 1'b0;
            ram_addr_q    <= '0;
            ram_store_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    dwait_q <= 2'b11;
                    iwait_q <= 2'b11;
                    if (quiet && |dreq) begin
                        r_q <= dsel;
                        if (dwen_i[dsel]) begin
                            state_q     <= MEMW;
                            ram_wen_q   <= 1'b1;
                            ram_addr_q  <= daddr_i[dsel];
                            ram_store_q <= dstore_i[dsel];
                        end else begin
                            ccwait_q[~dsel]      <= 1'b1;
                            ccsnoopaddr_q[~dsel] <= daddr_i[dsel];
                            if (dren_i[dsel]) begin
                                state_q        <= SNOOP;
                                ccinv_q[~dsel] <= ccwrite_i[dsel];
                            end else begin
                                state_q        <= INV;
                                ccinv_q[~dsel] <= 1'b1;
                                dwait_q[dsel]  <= 1'b0;
                                rr_q           <= ~dsel;
                            end
                        end
                    end else if (quiet && |iren_i) begin
                        r_q        <= isel;
                        state_q    <= IFETCH;
                        ram_ren_q  <= 1'b1;
                        ram_addr_q <= iaddr_i[isel];
                    end
                end
                SNOOP: begin
                    ccinv_q <= 2'b00;
                    if (cctrans_i[o] & ccwrite_i[o]) begin
                        state_q     <= FWD;
                        ram_wen_q   <= 1'b1;
                        ram_addr_q  <= daddr_i[o];
                        ram_store_q <= dstore_i[o];
                    end else begin
                        state_q    <= MEMR;
                        ccwait_q   <= 2'b00;
                        ram_ren_q  <= 1'b1;
                        ram_addr_q <= daddr_i[r_q];
                    end
                end
                INV: begin
                    state_q  <= IDLE;
                    ccwait_q <= 2'b00;
                    ccinv_q  <= 2'b00;
                    dwait_q  <= 2'b11;
                end
                FWD: if (acc) begin
                    state_q        <= IDLE;
                    ram_wen_q      <= 1'b0;
                    ccwait_q       <= 2'b00;
                    dwait_q        <= 2'b00;
                    dload_q[r_q]   <= ram_store_q;
                    rr_q           <= o;
                end
                MEMR: if (acc) begin
                    state_q      <= IDLE;
                    ram_ren_q    <= 1'b0;
                    dwait_q[r_q] <= 1'b0;
                    dload_q[r_q] <= ram_load_i;
                    rr_q         <= o;
                end
                MEMW: if (acc) begin
                    state_q      <= IDLE;
                    ram_wen_q    <= 1'b0;
                    dwait_q[r_q] <= 1'b0;
                    rr_q         <= o;
                end
                IFETCH: if (acc) begin
                    state_q      <= IDLE;
                    ram_ren_q    <= 1'b0;
                    iwait_q[r_q] <= 1'b0;
                    iload_q[r_q] <= ram_load_i;
                    irr_q        <= o;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign dwait_o       = dwait_q;
    assign iwait_o       = iwait_q;
    assign ccwait_o      = ccwait_q;
    assign ccinv_o       = ccinv_q;
    assign ccsnoopaddr_o = ccsnoopaddr_q;
    assign dload_o       = dload_q;
    assign iload_o       = iload_q;
    assign ram_ren_o     = ram_ren_q;
    assign ram_wen_o     = ram_wen_q;
    assign ram_addr_o    = ram_addr_q;
    assign ram_store_o   = ram_store_q;
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: scoreboard bench; stimulus queues expected done pulses, snoops and RAM writes, a negedge monitor checks them.
module tb_coherence_bus_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] dren, dwen, cctrans, ccwrite, iren;
    logic [1:0][31:0] daddr, dstore, iaddr;
    logic [1:0] dwait, ccwait, ccinv, iwait;
    logic [1:0][31:0] dload, ccsnoopaddr, iload;
    logic ram_ren, ram_wen;
    logic [31:0] ram_addr, ram_store, ram_load;
    logic [1:0] ram_state;
    logic ram_busy = 1'b0, ram_err = 1'b0;
    logic [1:0] resp_en;
    logic [31:0] resp_data;
    logic [31:0] mem [0:1023];
    int checks = 0, failures = 0;

    typedef struct packed { logic is_i; logic core; logic chk; logic pair; logic [31:0] data; } rsp_t;
    typedef struct packed { logic core; logic inv; logic done_now; logic [31:0] addr; } snp_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    rsp_t rq[$];
    snp_t sq[$];
    wr_t  wq[$];

    always #5 clk = ~clk;

    assign ram_load  = mem[ram_addr[11:2]];
    assign ram_state = !(ram_ren | ram_wen) ? 2'd0 : ram_err ? 2'd3 : ram_busy ? 2'd1 : 2'd2;

    coherence_bus_ctrl #(.WORD_W(32), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .dren_i(dren), .dwen_i(dwen), .daddr_i(daddr), .dstore_i(dstore),
        .cctrans_i(cctrans), .ccwrite_i(ccwrite), .iren_i(iren), .iaddr_i(iaddr),
        .dwait_o(dwait), .dload_o(dload), .ccwait_o(ccwait), .ccinv_o(ccinv), .ccsnoopaddr_o(ccsnoopaddr),
        .iwait_o(iwait), .iload_o(iload), .ram_ren_o(ram_ren), .ram_wen_o(ram_wen), .ram_addr_o(ram_addr),
        .ram_store_o(ram_store), .ram_load_i(ram_load), .ram_state_i(ram_state)
    );

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    logic [1:0] dprev = 2'b11, iprev = 2'b11, cprev = 2'b00;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_ren | ram_wen) check("ram_exclusive", {31'd0, ram_ren & ram_wen}, 32'd0);
            for (int c = 0; c < 2; c++) begin
                if (!dwait[c] || !iwait[c]) begin
                    rsp_t e;
                    check("done_pulse_width", {31'd0, !dwait[c] ? dprev[c] : iprev[c]}, 32'd1);
                    check("done_expected", {31'd0, rq.size() != 0}, 32'd1);
                    if (rq.size() != 0) begin
                        e = rq.pop_front();
                        check("done_kind", {31'd0, !iwait[c]}, {31'd0, e.is_i});
                        check("done_core", c, {31'd0, e.core});
                        if (e.chk) check("done_data", !iwait[c] ? iload[c] : dload[c], e.data);
                        if (e.pair) check("done_pair", {30'd0, dwait}, 32'd0);
                    end
                end
                if (ccwait[c] && !cprev[c]) begin
                    snp_t s;
                    check("snoop_expected", {31'd0, sq.size() != 0}, 32'd1);
                    if (sq.size() != 0) begin
                        s = sq.pop_front();
                        check("snoop_core", c, {31'd0, s.core});
                        check("snoop_addr", ccsnoopaddr[c], s.addr);
                        check("snoop_inv", {31'd0, ccinv[c]}, {31'd0, s.inv});
                        check("snoop_req_done", {31'd0, !dwait[1-c]}, {31'd0, s.done_now});
                    end
                end
            end
            if (ram_wen && ram_state == 2'd2) begin
                wr_t w;
                check("ramwr_expected", {31'd0, wq.size() != 0}, 32'd1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    check("ramwr_addr", ram_addr, w.addr);
                    check("ramwr_data", ram_store, w.data);
                end
                mem[ram_addr[11:2]] = ram_store;
            end
        end
        dprev = dwait;
        iprev = iwait;
        cprev = ccwait;
    end

    task automatic clear_inputs();
        dren = 0; dwen = 0; cctrans = 0; ccwrite = 0; iren = 0;
        daddr = '0; dstore = '0; iaddr = '0; resp_en = 0; resp_data = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // behaves as the two caches: reply to snoops when enabled, drop requests on done
    task automatic run(input int budget, output int ram_cycles);
        int n = 0;
        ram_cycles = 0;
        while ((rq.size() != 0 || sq.size() != 0 || wq.size() != 0 ||
                |{dren, dwen, cctrans, ccwrite, iren}) && n < budget) begin
            @(negedge clk);
            n++;
            if (ram_ren | ram_wen) ram_cycles++;
            for (int c = 0; c < 2; c++) begin
                if (ccwait[c] && resp_en[c]) begin
                    cctrans[c] = 1'b1; ccwrite[c] = 1'b1; dstore[c] = resp_data;
                end
                if (!dwait[c]) begin
                    dren[c] = 1'b0; dwen[c] = 1'b0; cctrans[c] = 1'b0; ccwrite[c] = 1'b0;
                end
                if (!iwait[c]) iren[c] = 1'b0;
            end
        end
        check("drain", rq.size() + sq.size() + wq.size(), 0);
        rq.delete(); sq.delete(); wq.delete();
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int rc;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h40 >> 2]  = 32'hCAFEF00D;
        do_reset();
        check("rst_dwait", {30'd0, dwait}, 32'd3);
        check("rst_iwait", {30'd0, iwait}, 32'd3);
        check("rst_ccwait", {30'd0, ccwait}, 32'd0);
        check("rst_ccinv", {30'd0, ccinv}, 32'd0);
        check("rst_ram_en", {30'd0, ram_ren, ram_wen}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_snoopaddr", ccsnoopaddr[1], 32'd0);

        // plain read, clean snoop
        sq.push_back('{core: 1'b1, inv: 1'b0, done_now: 1'b0, addr: 32'h100});
        rq.push_back('{is_i: 1'b0, core: 1'b0, chk: 1'b1, pair: 1'b0, data: 32'hDEADBEEF});
        dren[0] = 1'b1; daddr[0] = 32'h100;
        run(50, rc);

        // read with write intent, dirty forward from core1
        resp_en[1] = 1'b1; resp_data = 32'h12345678;
        sq.push_back('{core: 1'b1, inv: 1'b1, done_now: 1'b0, addr: 32'h200});
        wq.push_back('{addr: 32'h200, data: 32'h12345678});
        rq.push_back('{is_i: 1'b0, core: 1'b0, chk: 1'b1, pair: 1'b1, data: 32'h12345678});
        rq.push_back('{is_i: 1'b0, core: 1'b1, chk: 1'b0, pair: 1'b1, data: 32'h0});
        dren[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h200; daddr[1] = 32'h200;
        run(50, rc);

        // simultaneous write-backs, twice, from rr=0
        do_reset();
        for (int k = 0; k < 2; k++) begin
            wq.push_back('{addr: 32'h600 + 32'(8 * k), data: 32'h11111111 * (2 * k + 1)});
            wq.push_back('{addr: 32'h604 + 32'(8 * k), data: 32'h11111111 * (2 * k + 2)});
            rq.push_back('{is_i: 1'b0, core: 1'b0, chk: 1'b0, pair: 1'b0, data: 32'h0});
            rq.push_back('{is_i: 1'b0, core: 1'b1, chk: 1'b0, pair: 1'b0, data: 32'h0});
            dwen = 2'b11;
            daddr[0] = 32'h600 + 32'(8 * k); dstore[0] = 32'h11111111 * (2 * k + 1);
            daddr[1] = 32'h604 + 32'(8 * k); dstore[1] = 32'h11111111 * (2 * k + 2);
            run(60, rc);
        end

        // core1 reads back what it wrote
        sq.push_back('{core: 1'b0, inv: 1'b0, done_now: 1'b0, addr: 32'h604});
        rq.push_back('{is_i: 1'b0, core: 1'b1, chk: 1'b1, pair: 1'b0, data: 32'h22222222});
        dren[1] = 1'b1; daddr[1] = 32'h604;
        run(50, rc);

        // fetch waits behind data
        sq.push_back('{core: 1'b1, inv: 1'b0, done_now: 1'b0, addr: 32'h100});
        rq.push_back('{is_i: 1'b0, core: 1'b0, chk: 1'b1, pair: 1'b0, data: 32'hDEADBEEF});
        rq.push_back('{is_i: 1'b1, core: 1'b1, chk: 1'b1, pair: 1'b0, data: 32'hCAFEF00D});
        dren[0] = 1'b1; daddr[0] = 32'h100; iren[1] = 1'b1; iaddr[1] = 32'h40;
        run(60, rc);

        // invalidate-only
        sq.push_back('{core: 1'b1, inv: 1'b1, done_now: 1'b1, addr: 32'h300});
        rq.push_back('{is_i: 1'b0, core: 1'b0, chk: 1'b0, pair: 1'b0, data: 32'h0});
        cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h300;
        run(50, rc);
        check("inv_no_ram", rc, 0);

        // RAM ERROR is retried until ACCESS
        sq.push_back('{core: 1'b0, inv: 1'b0, done_now: 1'b0, addr: 32'h100});
        rq.push_back('{is_i: 1'b0, core: 1'b1, chk: 1'b1, pair: 1'b0, data: 32'hDEADBEEF});
        ram_err = 1'b1; dren[1] = 1'b1; daddr[1] = 32'h100;
        repeat (6) @(negedge clk);
        check("err_held", {31'd0, ram_ren}, 32'd1);
        ram_err = 1'b0;
        run(50, rc);

        // reset in the middle of a stalled write
        ram_busy = 1'b1; dwen[0] = 1'b1; daddr[0] = 32'h500; dstore[0] = 32'h55;
        for (int i = 0; i < 10 && !ram_wen; i++) @(negedge clk);
        check("memw_started", {31'd0, ram_wen}, 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_wen", {30'd0, ram_ren, ram_wen}, 32'd0);
        check("rst_async_dwait", {30'd0, dwait}, 32'd3);
        clear_inputs();
        ram_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_waits", {28'd0, dwait, iwait}, 32'hF);
        check("post_rst_ccwait", {30'd0, ccwait}, 32'd0);
        sq.push_back('{core: 1'b1, inv: 1'b0, done_now: 1'b0, addr: 32'h500});
        rq.push_back('{is_i: 1'b0, core: 1'b0, chk: 1'b1, pair: 1'b0, data: 32'h0});
        dren[0] = 1'b1; daddr[0] = 32'h500;
        run(50, rc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
